axi_rd_master: RTL and testbench

Parametrised multi-client AXI4 read master that replaces the single-client, single-outstanding fetch interface. It accepts single-beat read requests from `NCLIENT` pipeline clients (client 0 = instruction fetch, others = data). It arbitrates them round-robin onto one AR channel and keeps up to `MAX_OUTST` reads in flight per client. R beats are routed back by RID, and a per-client flush drops stale responses, so the IFU can redirect without waiting for in-flight fetches.

---
 rtl/axi_pkg.sv | 30 +++
 rtl/axi_rd_master_if.sv | 33 +++
 rtl/axi_rd_master_rr_arbiter.sv | 48 ++++
 rtl/axi_rd_master.sv | 149 ++++++++++++++
 tb/tb_axi_rd_master.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_pkg.sv
// Shared AXI4 encodings used by the read master and its bench.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] SIZE_1   = 3'd0;
  localparam logic [2:0] SIZE_2   = 3'd1;
  localparam logic [2:0] SIZE_4   = 3'd2;
  localparam logic [2:0] SIZE_8   = 3'd3;
  localparam logic [2:0] SIZE_16  = 3'd4;
  localparam logic [2:0] SIZE_32  = 3'd5;
  localparam logic [2:0] SIZE_64  = 3'd6;
  localparam logic [2:0] SIZE_128 = 3'd7;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [2:0] PROT_INSTR = 3'b100;
  localparam logic [2:0] PROT_DATA  = 3'b000;

  // Client 0 is instruction fetch; everyone else is a data access.
  function automatic logic [2:0] prot_for_client(input int c);
    return (c == 0) ? PROT_INSTR : PROT_DATA;
  endfunction

endpackage

// File: rtl/axi_rd_master_if.sv
// AXI4 read-only channel bundle (AR + R) with master/slave views.
interface axi_rd_master_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
) ();

  logic [ID_W-1:0]   ARID;
  logic [ADDR_W-1:0] ARADDR;
  logic [7:0]        ARLEN;
  logic [2:0]        ARSIZE;
  logic [1:0]        ARBURST;
  logic [2:0]        ARPROT;
  logic              ARVALID;
  logic              ARREADY;
  logic [ID_W-1:0]   RID;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RLAST;
  logic              RVALID;
  logic              RREADY;

  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARPROT, ARVALID, RREADY,
    input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );

  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARPROT, ARVALID, RREADY,
    output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );

endinterface

// File: rtl/axi_rd_master_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the search at the pointer;
// the pointer moves to grant+1 whenever the grant is taken (advance).
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_gidx;

  // Scan requesters from the pointer upwards, first one found wins.
  always_comb begin
    int   v_idx;
    logic v_take;
    logic v_found;
    gnt     = '0;
    w_gidx  = '0;
    v_idx   = 0;
    v_take  = 1'b0;
    v_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      v_idx      = (int'(r_ptr) + k) % N;
      v_take     = !v_found && req[v_idx];
      gnt[v_idx] = v_take;
      w_gidx     = v_take ? PW'(v_idx) : w_gidx;
      v_found    = v_found | v_take;
    end
  end

  // Priority pointer: next search starts just after the accepted grant.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ptr <= '0;
    end else if (advance) begin
      r_ptr <= (w_gidx == PW'(N - 1)) ? '0 : w_gidx + PW'(1);
    end else begin
      r_ptr <= r_ptr;
    end
  end

endmodule

// File: rtl/axi_rd_master.sv
// Multi-client single-beat AXI4 read master: round-robin AR issue from one
// holding slot, per-client outstanding/discard counters, RID-routed R beats.
module axi_rd_master
  import axi_pkg::*;
#(
  parameter int NCLIENT   = 2,
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int ID_W      = 4,
  parameter int MAX_OUTST = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NCLIENT-1:0]        req_valid,
  output logic [NCLIENT-1:0]        req_ready,
  input  logic [NCLIENT*ADDR_W-1:0] req_addr,
  input  logic [NCLIENT*3-1:0]      req_size,
  input  logic [NCLIENT-1:0]        flush,
  output logic [NCLIENT-1:0]        rsp_valid,
  input  logic [NCLIENT-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  axi_rd_master_if.master           axi
);

  localparam int CNT_W = $clog2(MAX_OUTST + 1);

  logic [NCLIENT-1:0] w_elig, w_gnt, w_req_hs, w_r_hs, w_rid_hit, w_rdy_client;
  logic               w_slot_ld, w_any_gnt, w_rid_oor;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [2:0]         w_sel_size, w_sel_prot;
  logic [ID_W-1:0]    w_sel_id;

  logic [CNT_W-1:0]   r_outst     [NCLIENT];
  logic [CNT_W-1:0]   r_disc      [NCLIENT];
  logic [CNT_W-1:0]   w_outst_nxt [NCLIENT];

  logic [ID_W-1:0]    r_arid;
  logic [ADDR_W-1:0]  r_araddr;
  logic [7:0]         r_arlen;
  logic [2:0]         r_arsize, r_arprot;
  logic [1:0]         r_arburst;
  logic               r_arvalid;

  // Slot can take a new request when empty or draining this cycle.
  assign w_slot_ld = !r_arvalid || axi.ARREADY;
  assign w_any_gnt = |w_gnt;
  assign req_ready = w_gnt & {NCLIENT{w_slot_ld}};
  assign w_req_hs  = req_ready & req_valid;

  rr_arbiter #(.N(NCLIENT)) u_arb (
    .clk     (clk),
    .rstn    (rstn),
    .req     (w_elig),
    .advance (w_any_gnt && w_slot_ld),
    .gnt     (w_gnt)
  );

  // Pick the granted client's request fields for the AR slot.
  always_comb begin
    w_sel_addr = '0;
    w_sel_size = '0;
    w_sel_id   = '0;
    w_sel_prot = PROT_DATA;
    for (int i = 0; i < NCLIENT; i++) begin
      w_sel_addr = w_gnt[i] ? req_addr[i*ADDR_W +: ADDR_W] : w_sel_addr;
      w_sel_size = w_gnt[i] ? req_size[i*3 +: 3]           : w_sel_size;
      w_sel_id   = w_gnt[i] ? ID_W'(i)                     : w_sel_id;
      w_sel_prot = w_gnt[i] ? prot_for_client(i)           : w_sel_prot;
    end
  end

  // AR slot: load on grant, hold until ARREADY, never withdrawn.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_arvalid <= 1'b0;
      r_arid    <= '0;
      r_araddr  <= '0;
      r_arlen   <= 8'd0;
      r_arsize  <= 3'd0;
      r_arburst <= 2'd0;
      r_arprot  <= 3'd0;
    end else if (w_slot_ld && w_any_gnt) begin
      r_arvalid <= 1'b1;
      r_arid    <= w_sel_id;
      r_araddr  <= w_sel_addr;
      r_arlen   <= 8'd0;
      r_arsize  <= w_sel_size;
      r_arburst <= BURST_INCR;
      r_arprot  <= w_sel_prot;
    end else if (w_slot_ld) begin
      r_arvalid <= 1'b0;
    end else begin
      r_arvalid <= r_arvalid;
    end
  end

  assign axi.ARVALID = r_arvalid;
  assign axi.ARID    = r_arid;
  assign axi.ARADDR  = r_araddr;
  assign axi.ARLEN   = r_arlen;
  assign axi.ARSIZE  = r_arsize;
  assign axi.ARBURST = r_arburst;
  assign axi.ARPROT  = r_arprot;

  for (genvar i = 0; i < NCLIENT; i++) begin : g_client
    assign w_rid_hit[i] = (axi.RID == ID_W'(i));
    assign w_elig[i]    = req_valid[i] && (r_outst[i] < CNT_W'(MAX_OUTST)) && !flush[i];
    assign w_r_hs[i]    = axi.RVALID && axi.RREADY && w_rid_hit[i];
    // Beats owed to a flush are swallowed here; others go to the client.
    assign rsp_valid[i]    = axi.RVALID && w_rid_hit[i] && (r_disc[i] == '0);
    assign w_rdy_client[i] = w_rid_hit[i] && ((r_disc[i] != '0) || rsp_ready[i]);

    // Outstanding count after this cycle's issue and return.
    always_comb begin
      if (w_req_hs[i] && !w_r_hs[i]) begin
        w_outst_nxt[i] = r_outst[i] + CNT_W'(1);
      end else if (!w_req_hs[i] && w_r_hs[i]) begin
        w_outst_nxt[i] = r_outst[i] - CNT_W'(1);
      end else begin
        w_outst_nxt[i] = r_outst[i];
      end
    end

    // Outstanding and discard counters; flush snapshots what is still owed.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_outst[i] <= '0;
        r_disc[i]  <= '0;
      end else begin
        r_outst[i] <= w_outst_nxt[i];
        if (flush[i]) begin
          r_disc[i] <= w_outst_nxt[i];
        end else if (w_r_hs[i] && (r_disc[i] != '0)) begin
          r_disc[i] <= r_disc[i] - CNT_W'(1);
        end else begin
          r_disc[i] <= r_disc[i];
        end
      end
    end
  end

  // IDs no client owns are accepted and dropped so the bus never stalls.
  assign w_rid_oor  = ~|w_rid_hit;
  assign axi.RREADY = w_rid_oor || (|w_rdy_client);
  assign rsp_data   = axi.RDATA;
  assign rsp_err    = (axi.RRESP != RESP_OKAY);

endmodule

// File: tb/tb_axi_rd_master.sv
// Directed bench for axi_rd_master with hand-computed expectations.
module tb_axi_rd_master;
  import axi_pkg::*;

  localparam int NC = 2;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int IW = 4;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic [NC-1:0]  req_valid, req_ready, flush, rsp_valid, rsp_ready;
  logic [NC*AW-1:0] req_addr;
  logic [NC*3-1:0]  req_size;
  logic [DW-1:0]  rsp_data;
  logic           rsp_err;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  axi_rd_master_if #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) axi ();

  axi_rd_master #(.NCLIENT(NC), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .MAX_OUTST(4)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_size  (req_size),
    .flush     (flush),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .axi       (axi)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic r_beat(input logic v, input logic [IW-1:0] id, input logic [DW-1:0] d, input logic [1:0] resp);
    axi.RVALID = v;
    axi.RID    = id;
    axi.RDATA  = d;
    axi.RRESP  = resp;
  endtask

  initial begin
    req_valid = '0; flush = '0; rsp_ready = '0;
    req_addr  = '0; req_size = '0;
    axi.ARREADY = 1'b0; axi.RLAST = 1'b1;
    r_beat(1'b0, '0, '0, RESP_OKAY);

    // Reset state
    step(); step();
    check("rst_arvalid", 64'(axi.ARVALID), 64'd0);
    check("rst_araddr",  axi.ARADDR, 64'd0);
    check("rst_arid",    64'(axi.ARID), 64'd0);
    check("rst_arprot",  64'(axi.ARPROT), 64'd0);
    check("rst_arburst", 64'(axi.ARBURST), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    rstn = 1'b1;
    step();

    // Single fetch by client 0
    req_addr[0 +: AW] = 64'h0000_0000_8000_0000;
    req_size[0 +: 3]  = SIZE_4;
    req_valid = 2'b01; axi.ARREADY = 1'b1;
    settle();
    check("t1_req_ready", 64'(req_ready), 64'd1);
    step();
    req_valid = 2'b00;
    check("t1_arvalid", 64'(axi.ARVALID), 64'd1);
    check("t1_arid",    64'(axi.ARID), 64'd0);
    check("t1_araddr",  axi.ARADDR, 64'h0000_0000_8000_0000);
    check("t1_arsize",  64'(axi.ARSIZE), 64'd2);
    check("t1_arlen",   64'(axi.ARLEN), 64'd0);
    check("t1_arburst", 64'(axi.ARBURST), 64'd1);
    check("t1_arprot",  64'(axi.ARPROT), 64'd4);
    step();
    r_beat(1'b1, 4'd0, 64'h0000_0000_0000_0513, RESP_OKAY);
    rsp_ready = 2'b01;
    settle();
    check("t1_rsp_valid", 64'(rsp_valid), 64'd1);
    check("t1_rsp_data",  rsp_data, 64'h513);
    check("t1_rsp_err",   64'(rsp_err), 64'd0);
    check("t1_rready",    64'(axi.RREADY), 64'd1);
    step();
    r_beat(1'b0, '0, '0, RESP_OKAY);

    // Reset so the pointer restarts at client 0
    rstn = 1'b0; step(); rstn = 1'b1; step();

    // Both clients saturate, ARIDs alternate
    req_addr[0 +: AW]  = 64'h1000;
    req_addr[AW +: AW] = 64'h2000;
    req_size = {SIZE_8, SIZE_4};
    for (int c = 0; c < 8; c++) begin
      req_valid = 2'b11;
      settle();
      check("t2_req_ready", 64'(req_ready), (c % 2 == 0) ? 64'd1 : 64'd2);
      step();
      check("t2_arid",   64'(axi.ARID), 64'(c % 2));
      check("t2_araddr", axi.ARADDR, (c % 2 == 0) ? 64'h1000 : 64'h2000);
      check("t2_arprot", 64'(axi.ARPROT), (c % 2 == 0) ? 64'd4 : 64'd0);
    end
    settle();
    check("t2_sat_ready", 64'(req_ready), 64'd0);
    step();
    check("t2_sat_arvalid", 64'(axi.ARVALID), 64'd0);
    check("t2_sat_ready2",  64'(req_ready), 64'd0);

    // SLVERR on client 1 frees one slot
    r_beat(1'b1, 4'd1, 64'hDEAD, RESP_SLVERR);
    rsp_ready = 2'b11;
    settle();
    check("t5_rsp_valid", 64'(rsp_valid), 64'd2);
    check("t5_rsp_err",   64'(rsp_err), 64'd1);
    check("t5_rready",    64'(axi.RREADY), 64'd1);
    check("t5_req_ready", 64'(req_ready), 64'd0);
    step();
    r_beat(1'b0, '0, '0, RESP_OKAY);
    settle();
    check("t5_req_ready_after", 64'(req_ready), 64'd2);
    step();
    req_valid = 2'b00;
    check("t5_arid", 64'(axi.ARID), 64'd1);

    // Drain all eight outstanding reads
    for (int k = 0; k < 8; k++) begin
      r_beat(1'b1, IW'(k % 2), 64'(256 + k), RESP_OKAY);
      settle();
      check("t2_drain_valid", 64'(rsp_valid), (k % 2 == 0) ? 64'd1 : 64'd2);
      check("t2_drain_data",  rsp_data, 64'(256 + k));
      check("t2_drain_err",   64'(rsp_err), 64'd0);
      step();
    end
    r_beat(1'b0, '0, '0, RESP_OKAY);

    // AR stall: slot held stable, no new acceptance
    req_addr[0 +: AW]  = 64'h3000;
    req_addr[AW +: AW] = 64'h4000;
    axi.ARREADY = 1'b0;
    req_valid = 2'b01;
    settle();
    check("t3_first_ready", 64'(req_ready), 64'd1);
    step();
    req_valid = 2'b11;
    for (int c = 0; c < 5; c++) begin
      settle();
      check("t3_stall_ready",   64'(req_ready), 64'd0);
      check("t3_stall_arvalid", 64'(axi.ARVALID), 64'd1);
      check("t3_stall_araddr",  axi.ARADDR, 64'h3000);
      check("t3_stall_arid",    64'(axi.ARID), 64'd0);
      step();
    end
    axi.ARREADY = 1'b1;
    settle();
    check("t3_rr_ready", 64'(req_ready), 64'd2);
    step();
    req_valid = 2'b00;
    check("t3_arid",   64'(axi.ARID), 64'd1);
    check("t3_araddr", axi.ARADDR, 64'h4000);
    step();
    for (int k = 0; k < 2; k++) begin
      r_beat(1'b1, IW'(k), 64'(k), RESP_OKAY);
      settle();
      check("t3_drain_valid", 64'(rsp_valid), (k == 0) ? 64'd1 : 64'd2);
      step();
    end
    r_beat(1'b0, '0, '0, RESP_OKAY);

    // Flush with three in flight (last still in AR slot)
    req_addr[0 +: AW] = 64'h7000;
    for (int c = 0; c < 3; c++) begin
      req_valid = 2'b01;
      settle();
      check("t4_issue_ready", 64'(req_ready), 64'd1);
      step();
    end
    flush = 2'b01;
    settle();
    check("t4_flush_ready", 64'(req_ready), 64'd0);
    step();
    flush = 2'b00;
    req_addr[0 +: AW] = 64'h5000;
    settle();
    check("t4_post_ready", 64'(req_ready), 64'd1);
    step();
    req_valid = 2'b00;
    check("t4_post_araddr", axi.ARADDR, 64'h5000);
    step();
    rsp_ready = 2'b00;
    for (int k = 0; k < 3; k++) begin
      r_beat(1'b1, 4'd0, 64'hBAD0 + 64'(k), RESP_OKAY);
      settle();
      check("t4_disc_valid",  64'(rsp_valid), 64'd0);
      check("t4_disc_rready", 64'(axi.RREADY), 64'd1);
      step();
    end
    r_beat(1'b1, 4'd0, 64'h5555, RESP_OKAY);
    settle();
    check("t4_live_valid",  64'(rsp_valid), 64'd1);
    check("t4_live_rready", 64'(axi.RREADY), 64'd0);
    step();
    check("t4_live_held", 64'(rsp_valid), 64'd1);
    rsp_ready = 2'b01;
    settle();
    check("t4_live_rready2", 64'(axi.RREADY), 64'd1);
    check("t4_live_data",    rsp_data, 64'h5555);
    step();
    r_beat(1'b0, '0, '0, RESP_OKAY);
    rsp_ready = 2'b00;

    // Response backpressure on client 1, then reset mid-stall
    req_addr[AW +: AW] = 64'h6000;
    req_valid = 2'b10;
    settle();
    check("t6_c1_ready", 64'(req_ready), 64'd2);
    step();
    req_valid = 2'b01;
    settle();
    check("t6_c0_ready", 64'(req_ready), 64'd1);
    step();
    req_valid = 2'b00;
    axi.ARREADY = 1'b0;
    r_beat(1'b1, 4'd1, 64'h6666, RESP_OKAY);
    for (int c = 0; c < 3; c++) begin
      settle();
      check("t6_hold_valid",   64'(rsp_valid), 64'd2);
      check("t6_hold_rready",  64'(axi.RREADY), 64'd0);
      check("t6_hold_arvalid", 64'(axi.ARVALID), 64'd1);
      step();
    end
    #2;
    rstn = 1'b0;
    #1;
    check("t6_rst_arvalid", 64'(axi.ARVALID), 64'd0);
    check("t6_rst_araddr",  axi.ARADDR, 64'd0);
    check("t6_rst_arprot",  64'(axi.ARPROT), 64'd0);
    r_beat(1'b0, '0, '0, RESP_OKAY);
    step(); step();
    rstn = 1'b1;
    step();
    axi.ARREADY = 1'b1;
    req_valid = 2'b01;
    for (int c = 0; c < 4; c++) begin
      settle();
      check("t6_refill_ready", 64'(req_ready), 64'd1);
      step();
    end
    settle();
    check("t6_refill_sat", 64'(req_ready), 64'd0);
    req_valid = 2'b00;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
